axi_cfg_sequencer: RTL

Command-table sequencer that drives the user-side request interface of the AXI4-Lite master (`valid`, `aw_addr`, `w_data`, `w_strb`, `read_valid`, `ar_addr`, `ready`). Software or a bench loads up to N_CMD commands: write, read-and-compare, wait, or end. After `start`, the block replays them in order, one outstanding transaction at a time, and reports completion or the first failing entry. Its purpose is to bring up and configure slaves behind the master without a CPU.

---
 rtl/axi_cfg_sequencer.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_cfg_sequencer.sv
// axi_cfg_sequencer: replays a small command table (WRITE, READ_CMP, WAIT, END) through the
// user-side request port of an AXI4-Lite master, one outstanding transaction at a time.
// Optional feature: define SEQ_TIMEOUT_EN to enable the WAIT_RDY watchdog (err_code 11).
module axi_cfg_sequencer #(
   parameter int unsigned N_CMD   = 8,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 64,
   localparam int unsigned STRB_W = DATA_W / 8,
   localparam int unsigned IDX_W  = $clog2(N_CMD)
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              cmd_we,
   input  logic [IDX_W-1:0]  cmd_idx,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [STRB_W-1:0] cmd_strb,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [IDX_W-1:0]  err_idx,
   output logic [1:0]        err_code,
   output logic              valid,
   output logic [ADDR_W-1:0] aw_addr,
   output logic [DATA_W-1:0] w_data,
   output logic [STRB_W-1:0] w_strb,
   output logic              read_valid,
   output logic [ADDR_W-1:0] ar_addr,
   input  logic              ready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_resp
);

   localparam logic [1:0] OpEnd   = 2'b00;
   localparam logic [1:0] OpWrite = 2'b01;
   localparam logic [1:0] OpRead  = 2'b10;
   localparam logic [1:0] OpWait  = 2'b11;

   localparam logic [1:0] ErrNone = 2'b00;
   localparam logic [1:0] ErrResp = 2'b01;
   localparam logic [1:0] ErrCmp  = 2'b10;

   if (N_CMD < 2 || N_CMD > 64 || (N_CMD & (N_CMD - 1)) != 0 || TIMEOUT < 1 || DATA_W < 16)
   begin : g_param_check
      $error("axi_cfg_sequencer: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      StIdle, StFetch, StIssue, StWaitRdy, StDelay, StDone, StErr
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic [IDX_W-1:0]    err_idx_q, err_idx_d;
   logic [1:0]          err_code_q, err_code_d;
   logic                advance;

   logic [1:0]          tbl_op_q   [N_CMD];
   logic [ADDR_W-1:0]   tbl_addr_q [N_CMD];
   logic [DATA_W-1:0]   tbl_data_q [N_CMD];
   logic [STRB_W-1:0]   tbl_strb_q [N_CMD];

   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [STRB_W-1:0]   strb_q;

   logic [DATA_W-1:0]   cmp_mask;
   logic                rd_mismatch;

`ifdef SEQ_TIMEOUT_EN
   localparam logic [1:0] ErrTimeout = 2'b11;
   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0]     wd_q, wd_d;
`endif

   assign busy = (state_q == StFetch) || (state_q == StIssue) ||
                 (state_q == StWaitRdy) || (state_q == StDelay);

   // Command table; an empty slot reads as END, and writes are locked out while running.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         for (int i = 0; i < N_CMD; i++) begin
            tbl_op_q[i]   <= OpEnd;
            tbl_addr_q[i] <= '0;
            tbl_data_q[i] <= '0;
            tbl_strb_q[i] <= '0;
         end
      end else if (cmd_we && !busy) begin
         tbl_op_q[cmd_idx]   <= cmd_op;
         tbl_addr_q[cmd_idx] <= cmd_addr;
         tbl_data_q[cmd_idx] <= cmd_data;
         tbl_strb_q[cmd_idx] <= cmd_strb;
      end
   end

   // Latch the fetched entry; it stays on the request outputs until the next fetch.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         op_q   <= OpEnd;
         addr_q <= '0;
         data_q <= '0;
         strb_q <= '0;
      end else if (state_q == StFetch) begin
         op_q   <= tbl_op_q[idx_q];
         addr_q <= tbl_addr_q[idx_q];
         data_q <= tbl_data_q[idx_q];
         strb_q <= tbl_strb_q[idx_q];
      end
   end

   // Expand the byte mask and flag any selected byte that differs from the expectation.
   always_comb begin
      cmp_mask = '0;
      for (int b = 0; b < STRB_W; b++) begin
         cmp_mask[b*8 +: 8] = {8{strb_q[b]}};
      end
      rd_mismatch = |((m_rdata ^ data_q) & cmp_mask);
   end

   // Sequencer state and status registers.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_idx_q  <= '0;
         err_code_q <= ErrNone;
`ifdef SEQ_TIMEOUT_EN
         wd_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_idx_q  <= err_idx_d;
         err_code_q <= err_code_d;
`ifdef SEQ_TIMEOUT_EN
         wd_q       <= wd_d;
`endif
      end
   end

   // Next-state decode, table walk and status flag updates.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      done_d     = done_q;
      error_d    = error_q;
      err_idx_d  = err_idx_q;
      err_code_d = err_code_q;
      advance    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_d       = wd_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StFetch;
               idx_d      = '0;
               done_d     = 1'b0;
               error_d    = 1'b0;
               err_idx_d  = '0;
               err_code_d = ErrNone;
            end
         end
         StFetch: begin
            case (tbl_op_q[idx_q])
               OpEnd:   state_d = StDone;
               OpWait: begin
                  cnt_d   = tbl_data_q[idx_q][15:0];
                  state_d = StDelay;
               end
               default: state_d = StIssue;
            endcase
         end
         StIssue: begin
            state_d = StWaitRdy;
`ifdef SEQ_TIMEOUT_EN
            wd_d    = '0;
`endif
         end
         StWaitRdy: begin
            if (ready) begin
               if (m_resp != 2'b00) begin
                  state_d    = StErr;
                  err_code_d = ErrResp;
               end else if (op_q == OpRead && rd_mismatch) begin
                  state_d    = StErr;
                  err_code_d = ErrCmp;
               end else begin
                  advance = 1'b1;
               end
            end
`ifdef SEQ_TIMEOUT_EN
            else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               state_d    = StErr;
               err_code_d = ErrTimeout;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
`endif
         end
         StDelay: begin
            if (cnt_q == 16'd0) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StDone, StErr: state_d = StIdle;
         default:       state_d = StIdle;
      endcase

      // The table does not wrap: finishing the last slot completes the sequence.
      if (advance) begin
         if (idx_q == IDX_W'(N_CMD - 1)) begin
            state_d = StDone;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StFetch;
         end
      end

      if (state_d == StDone) begin
         done_d = 1'b1;
      end
      if (state_d == StErr) begin
         error_d   = 1'b1;
         err_idx_d = idx_q;
      end
   end

   assign done       = done_q;
   assign error      = error_q;
   assign err_idx    = err_idx_q;
   assign err_code   = err_code_q;
   assign valid      = (state_q == StIssue) && (op_q == OpWrite);
   assign read_valid = (state_q == StIssue) && (op_q == OpRead);
   assign aw_addr    = addr_q;
   assign w_data     = data_q;
   assign w_strb     = strb_q;
   assign ar_addr    = addr_q;

endmodule
